sa_ctrl: RTL and testbench

SA_CTRL -- requirements
Module: sa_ctrl

---
 rtl/sa_ctrl_if.sv | 22 ++
 rtl/sa_ctrl.sv | 76 +++++++
 tb/tb_sa_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/sa_ctrl_if.sv
// sa_ctrl_if: tile-control and skewed-data bundle between a vector source, sa_ctrl and the systolic array
interface sa_ctrl_if #(
  parameter int D_W = 8,
  parameter int SA_R = 16,
  parameter int SA_C = 16,
  parameter int CNT_W = 8
);
  logic start;
  logic [CNT_W-1:0] vec_num;
  logic x_valid;
  logic [SA_R-1:0][D_W-1:0] x;
  logic x_ready;
  logic load_signal;
  logic [SA_R-1:0][D_W-1:0] sa_x;
  logic [SA_C-1:0] col_valid;
  logic busy;
  logic done;
  modport master (output start, vec_num, x_valid, x,
                  input x_ready, load_signal, sa_x, col_valid, busy, done);
  modport slave (input start, vec_num, x_valid, x,
                 output x_ready, load_signal, sa_x, col_valid, busy, done);
endinterface

// File: rtl/sa_ctrl.sv
// sa_ctrl: systolic-array tile sequencer with input skew and per-column valid tags
module sa_ctrl #(
  parameter int D_W = 8,
  parameter int SA_R = 16,
  parameter int SA_C = 16,
  parameter int PE_LAT = 1,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst_n,
  sa_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD, STREAM, DRAIN, DONE} state_t;
  localparam int DRN = SA_R + SA_C - 2 + PE_LAT;
  localparam int DCW = DRN > 1 ? $clog2(DRN) : 1;
  state_t state, state_nx;
  logic [CNT_W-1:0] m_q, cnt;
  logic [DCW-1:0] dcnt;
  logic hs;
  logic [SA_R-1:0][D_W-1:0] entry, sx;
  logic [DRN-1:0] tag_q;
  logic [DRN:0] tag;
  assign hs = state == STREAM && bus.x_valid;
  assign entry = hs ? bus.x : '0;
  assign tag = {tag_q, hs};
  assign bus.x_ready = hs;
  assign bus.load_signal = state == LOAD;
  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE;
  assign bus.sa_x = sx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = bus.start ? LOAD : IDLE;
      LOAD: state_nx = m_q != '0 ? STREAM : DONE;
      STREAM: state_nx = hs && cnt == m_q - CNT_W'(1) ? DRAIN : STREAM;
      DRAIN: state_nx = dcnt == DCW'(DRN - 1) ? DONE : DRAIN;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    bus.col_valid = '0;
    for (int j = 0; j < SA_C; j++) bus.col_valid[j] = tag[SA_R-1+j+PE_LAT];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      m_q <= '0;
      cnt <= '0;
      dcnt <= '0;
      tag_q <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && bus.start) m_q <= bus.vec_num;
      cnt <= state == STREAM ? cnt + CNT_W'(hs) : '0;
      dcnt <= state == DRAIN ? dcnt + DCW'(1) : '0;
      tag_q <= tag[DRN-1:0];
    end
  end
  for (genvar i = 0; i < SA_R; i++) begin : g_row
    if (i == 0) begin : g_first
      assign sx[0] = entry[0];
    end else begin : g_dly
      logic [i-1:0][D_W-1:0] sr;
      always_ff @(posedge clk) begin
        if (!rst_n) sr <= '0;
        else begin
          sr[0] <= entry[i];
          for (int k = 1; k < i; k++) sr[k] <= sr[k-1];
        end
      end
      assign sx[i] = sr[i-1];
    end
  end
endmodule

// File: tb/tb_sa_ctrl.sv
// tb_sa_ctrl: directed checks of tile sequencing, skew, valid tags, reset abort and full-range count
module tb_sa_ctrl;
  localparam int D_W = 8;
  localparam int SA_R = 4;
  localparam int SA_C = 4;
  localparam int PE_LAT = 1;
  localparam int CNT_W = 8;
  logic clk = 0;
  logic rst_n = 0;
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] exp_sx [16];
  logic [3:0] exp_cv [16];
  logic [15:0] exp_rdy, exp_busy, exp_done;
  sa_ctrl_if #(.D_W(D_W), .SA_R(SA_R), .SA_C(SA_C), .CNT_W(CNT_W)) bus ();
  sa_ctrl #(.D_W(D_W), .SA_R(SA_R), .SA_C(SA_C), .PE_LAT(PE_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] vec(input int k);
    return {8'(4 + 16 * k), 8'(3 + 16 * k), 8'(2 + 16 * k), 8'(1 + 16 * k)};
  endfunction
  task automatic clear_exp;
    for (int c = 0; c < 16; c++) begin
      exp_sx[c] = '0;
      exp_cv[c] = '0;
    end
  endtask
  task automatic run_tile(input int m, input logic [15:0] vpat, input logic [15:0] spat, input int ncyc);
    int k = 0;
    bus.start = 1;
    bus.vec_num = CNT_W'(m);
    @(negedge clk);
    check("start idle busy", 32'(bus.busy), 0);
    tick;
    bus.start = 0;
    @(negedge clk);
    check("load strobe", 32'(bus.load_signal), 1);
    check("load rdy", 32'(bus.x_ready), 0);
    tick;
    for (int c = 0; c < ncyc; c++) begin
      bus.x_valid = vpat[c];
      bus.start = spat[c];
      bus.vec_num = 8'd7;
      bus.x = vpat[c] ? vec(k) : 32'hFFFF_FFFF;
      if (vpat[c]) k++;
      @(negedge clk);
      check($sformatf("m%0d rdy c%0d", m, c), 32'(bus.x_ready), 32'(exp_rdy[c]));
      check($sformatf("m%0d busy c%0d", m, c), 32'(bus.busy), 32'(exp_busy[c]));
      check($sformatf("m%0d done c%0d", m, c), 32'(bus.done), 32'(exp_done[c]));
      check($sformatf("m%0d load c%0d", m, c), 32'(bus.load_signal), 0);
      check($sformatf("m%0d cv c%0d", m, c), 32'(bus.col_valid), 32'(exp_cv[c]));
      check($sformatf("m%0d sx c%0d", m, c), bus.sa_x, exp_sx[c]);
      tick;
    end
    bus.start = 0;
    bus.x_valid = 0;
  endtask
  initial begin
    int hs_n, done_n;
    bus.start = 0;
    bus.vec_num = '0;
    bus.x_valid = 0;
    bus.x = '0;
    repeat (2) tick;
    @(negedge clk);
    check("rst sx", bus.sa_x, 0);
    check("rst cv", 32'(bus.col_valid), 0);
    check("rst busy", 32'(bus.busy), 0);
    check("rst done", 32'(bus.done), 0);
    check("rst load", 32'(bus.load_signal), 0);
    check("rst rdy", 32'(bus.x_ready), 0);
    rst_n = 1;
    tick;
    clear_exp();
    exp_sx[0] = 32'h00000001; exp_sx[1] = 32'h00000211; exp_sx[2] = 32'h00031221;
    exp_sx[3] = 32'h04132200; exp_sx[4] = 32'h14230000; exp_sx[5] = 32'h24000000;
    exp_cv[4] = 4'h1; exp_cv[5] = 4'h3; exp_cv[6] = 4'h7;
    exp_cv[7] = 4'hE; exp_cv[8] = 4'hC; exp_cv[9] = 4'h8;
    exp_rdy = 16'h0007; exp_busy = 16'h07FF; exp_done = 16'h0400;
    run_tile(3, 16'hFFFF, 16'h0000, 12);
    clear_exp();
    exp_sx[0] = 32'h00000001; exp_sx[1] = 32'h00000200; exp_sx[2] = 32'h00030011;
    exp_sx[3] = 32'h04001221; exp_sx[4] = 32'h00132200; exp_sx[5] = 32'h14230000;
    exp_sx[6] = 32'h24000000;
    exp_cv[4] = 4'h1; exp_cv[5] = 4'h2; exp_cv[6] = 4'h5; exp_cv[7] = 4'hB;
    exp_cv[8] = 4'h6; exp_cv[9] = 4'hC; exp_cv[10] = 4'h8;
    exp_rdy = 16'h000D; exp_busy = 16'h0FFF; exp_done = 16'h0800;
    run_tile(3, 16'h000D, 16'h0002, 13);
    clear_exp();
    exp_rdy = 16'h0000; exp_busy = 16'h0001; exp_done = 16'h0001;
    run_tile(0, 16'h0003, 16'h0000, 2);
    clear_exp();
    exp_sx[0] = 32'h00000001; exp_sx[1] = 32'h00000200;
    exp_rdy = 16'h0001; exp_busy = 16'h0003; exp_done = 16'h0000;
    run_tile(1, 16'h0001, 16'h0000, 2);
    rst_n = 0;
    tick;
    rst_n = 1;
    @(negedge clk);
    check("abort sx", bus.sa_x, 0);
    check("abort cv", 32'(bus.col_valid), 0);
    check("abort busy", 32'(bus.busy), 0);
    check("abort done", 32'(bus.done), 0);
    check("abort load", 32'(bus.load_signal), 0);
    check("abort rdy", 32'(bus.x_ready), 0);
    done_n = 0;
    hs_n = 0;
    for (int c = 0; c < 8; c++) begin
      tick;
      @(negedge clk);
      if (bus.done) done_n++;
      if (bus.col_valid != '0) hs_n++;
    end
    check("abort late done", 32'(done_n), 0);
    check("abort late cv", 32'(hs_n), 0);
    tick;
    bus.start = 1;
    bus.vec_num = 8'd255;
    bus.x_valid = 1;
    bus.x = vec(5);
    tick;
    bus.start = 0;
    hs_n = 0;
    done_n = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (bus.x_ready) hs_n++;
      if (bus.done) done_n++;
      if (!bus.busy && done_n > 0) break;
      tick;
    end
    bus.x_valid = 0;
    check("m255 handshakes", 32'(hs_n), 255);
    check("m255 done pulses", 32'(done_n), 1);
    check("m255 idle", 32'(bus.busy), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
